game_loop_ctrl: RTL and testbench

- Parametrised game-loop controller. Owns the global game state machine, frame stepping, speed ramp and obstacle clear timer.
- Generalised over the existing fixed-function loop:
  - N-channel crash input vector.
  - Pause/resume.
  - Timed restart after a crash, without a global reset.
- Sits between the painter, which provides frame-done, and the world modules (trex, horizon, distance meter). Those modules consume update/timer/speed/state.

---
 rtl/game_loop_pkg.sv | 16 +
 rtl/game_loop_ctrl_speed_ramp.sv | 25 ++
 rtl/game_loop_ctrl.sv | 118 +++++++++++
 tb/tb_game_loop_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/game_loop_pkg.sv
// game_loop_pkg: shared state encoding and default tuning constants for the game loop.
package game_loop_pkg;
    typedef enum logic [1:0] {
        WAITING = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        CRASHED = 2'd3
    } state_t;

    localparam int FPS           = 60;
    localparam int SPEED_SCALE   = 1024;
    localparam int SPEED_INIT    = 6144;
    localparam int MAX_SPEED     = 13312;
    localparam int CLEAR_TIME    = 180;
    localparam int RESTART_DELAY = 45;
endpackage

// File: rtl/game_loop_ctrl_speed_ramp.sv
// speed_ramp: speed register with load, saturating step and hold.
module speed_ramp #(
    parameter int SPEED_W      = 15,
    parameter int SPEED_INIT   = game_loop_pkg::SPEED_INIT,
    parameter int MAX_SPEED    = game_loop_pkg::MAX_SPEED,
    parameter int ACCELERATION = 1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               hold,
    output logic [SPEED_W-1:0] speed
);
    logic [SPEED_W:0] sum;

    // one extra bit so the add can never wrap before the ceiling compare
    assign sum = {1'b0, speed} + (SPEED_W + 1)'(ACCELERATION);

    always_ff @(posedge clk or posedge rst)
        if (rst) speed <= '0;
        else speed <= load ? SPEED_W'(SPEED_INIT)
                    : (step && !hold) ? ((sum > (SPEED_W + 1)'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED) : sum[SPEED_W-1:0])
                    : speed;
endmodule

// File: rtl/game_loop_ctrl.sv
// game_loop_ctrl: global game FSM, frame stepping, speed ramp and obstacle clear timer.
// GAME_LOOP_WATCHDOG_EN adds a synthetic update after WATCHDOG_CYCLES without a painter edge.
module game_loop_ctrl
    import game_loop_pkg::*;
#(
    parameter int FPS           = game_loop_pkg::FPS,
    parameter int SPEED_W       = 15,
    parameter int SPEED_INIT    = game_loop_pkg::SPEED_INIT,
    parameter int MAX_SPEED     = game_loop_pkg::MAX_SPEED,
    parameter int ACCELERATION  = 1,
    parameter int CLEAR_TIME    = game_loop_pkg::CLEAR_TIME,
    parameter int RESTART_DELAY = game_loop_pkg::RESTART_DELAY,
    parameter int NUM_COLLIDERS = 4
`ifdef GAME_LOOP_WATCHDOG_EN
    , parameter int WATCHDOG_CYCLES = 1111111
`endif
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     painter_finished,
    input  logic                     jumping,
    input  logic                     pause,
    input  logic [NUM_COLLIDERS-1:0] crash_req,
    output logic                     update,
    output logic [$clog2(FPS)-1:0]   timer,
    output state_t                   state,
    output logic                     start,
    output logic                     restart,
    output logic [SPEED_W-1:0]       speed,
    output logic                     has_obstacles,
    output logic [SPEED_W-1:0]       frozen_speed
);
    localparam int TW = $clog2(FPS);
    localparam int CW = $clog2(RESTART_DELAY + 1);

    logic          painter_last, pause_last, pend;
    logic          frame_edge, step, crash, live, cnt_done, load;
    logic [7:0]    clear_timer, ct_next;
    logic [CW-1:0] crash_cnt;

    assign frame_edge = painter_finished && !painter_last;
    assign crash      = (state == RUNNING) && (|crash_req);
    assign live       = (state == RUNNING) || (state == PAUSED);
    assign cnt_done   = crash_cnt == CW'(RESTART_DELAY);
    assign load       = update && jumping && ((state == WAITING) || ((state == CRASHED) && cnt_done));
    assign ct_next    = (clear_timer == 8'hff) ? 8'hff : clear_timer + 8'd1;

`ifdef GAME_LOOP_WATCHDOG_EN
    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
    logic [WW-1:0] wd_cnt;
    assign step = frame_edge || (wd_cnt == WW'(WATCHDOG_CYCLES - 1));
    always_ff @(posedge clk or posedge rst)
        if (rst) wd_cnt <= '0;
        else wd_cnt <= step ? '0 : wd_cnt + 1'b1;
`else
    assign step = frame_edge;
`endif

    speed_ramp #(
        .SPEED_W(SPEED_W), .SPEED_INIT(SPEED_INIT), .MAX_SPEED(MAX_SPEED), .ACCELERATION(ACCELERATION)
    ) u_ramp (
        .clk(clk), .rst(rst), .load(load), .step(update && !pend),
        .hold((state != RUNNING) || crash), .speed(speed)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            painter_last  <= 1'b0;
            pause_last    <= 1'b0;
            pend          <= 1'b0;
            update        <= 1'b0;
            timer         <= '0;
            state         <= WAITING;
            start         <= 1'b0;
            restart       <= 1'b0;
            has_obstacles <= 1'b0;
            frozen_speed  <= '0;
            clear_timer   <= '0;
            crash_cnt     <= '0;
        end else begin
            painter_last <= painter_finished;
            pause_last   <= pause;
            update       <= step;
            restart      <= 1'b0;
            if (step) timer <= (timer == TW'(FPS - 1)) ? '0 : timer + 1'b1;
            // a pause edge waits for the next update; an edge in the update cycle itself waits for the one after
            pend <= !crash && live && ((pend && !update) || (pause && !pause_last));
            case (state)
                WAITING: if (update && jumping) begin
                    state       <= RUNNING;
                    start       <= 1'b1;
                    clear_timer <= '0;
                end
                RUNNING: if (crash) begin
                    state        <= CRASHED;
                    frozen_speed <= speed;
                    crash_cnt    <= '0;
                end else if (update && pend) begin
                    state <= PAUSED;
                end else if (update) begin
                    clear_timer   <= ct_next;
                    has_obstacles <= has_obstacles || (ct_next > 8'(CLEAR_TIME));
                end
                PAUSED: if (update && pend) state <= RUNNING;
                CRASHED: if (update) begin
                    if (jumping && cnt_done) begin
                        state         <= RUNNING;
                        restart       <= 1'b1;
                        clear_timer   <= '0;
                        has_obstacles <= 1'b0;
                    end else if (!cnt_done) begin
                        crash_cnt <= crash_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_loop_ctrl.sv
// tb_game_loop_ctrl: directed scenarios for game_loop_ctrl, plus a near-ceiling ramp instance.
module tb_game_loop_ctrl;
    localparam logic [1:0] S_WAIT = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_CRASH = 2'd3;

    logic        clk = 1'b0, rst = 1'b1;
    logic        painter_finished = 1'b0, jumping = 1'b0, pause = 1'b0;
    logic [3:0]  crash_req = 4'b0;
    logic        update, start, restart, has_obstacles;
    logic [5:0]  timer;
    logic [1:0]  state;
    logic [14:0] speed, frozen_speed;
    logic        s_update, s_start, s_restart, s_has_obstacles;
    logic [5:0]  s_timer;
    logic [1:0]  s_state;
    logic [14:0] s_speed, s_frozen_speed;
    logic        upd_seen, upd_after;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    game_loop_ctrl #(
`ifdef GAME_LOOP_WATCHDOG_EN
        .WATCHDOG_CYCLES(100)
`endif
    ) u_dut (
        .clk(clk), .rst(rst), .painter_finished(painter_finished), .jumping(jumping), .pause(pause),
        .crash_req(crash_req), .update(update), .timer(timer), .state(state), .start(start),
        .restart(restart), .speed(speed), .has_obstacles(has_obstacles), .frozen_speed(frozen_speed)
    );

    game_loop_ctrl #(.MAX_SPEED(6150), .ACCELERATION(4)) u_sat (
        .clk(clk), .rst(rst), .painter_finished(painter_finished), .jumping(jumping), .pause(pause),
        .crash_req(crash_req), .update(s_update), .timer(s_timer), .state(s_state), .start(s_start),
        .restart(s_restart), .speed(s_speed), .has_obstacles(s_has_obstacles), .frozen_speed(s_frozen_speed)
    );

    // one painter rising edge; jumping is held across the update cycle when j=1
    task automatic frame(input logic j);
        @(posedge clk); #1 painter_finished = 1'b1;
        @(posedge clk); #1 painter_finished = 1'b0; jumping = j; upd_seen = update;
        @(posedge clk); #1 jumping = 1'b0; upd_after = update;
    endtask

    task automatic pause_edge();
        @(posedge clk); #1 pause = 1'b1;
        @(posedge clk); #1 pause = 1'b0;
    endtask

    task automatic recover();
        for (int k = 1; k <= 46; k++) frame(k == 46);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (state !== S_WAIT) begin errors++; $display("FAIL reset_state: got %0d exp %0d", state, S_WAIT); end
        checks++; if ({update, start, restart, has_obstacles} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {update, start, restart, has_obstacles}); end
        checks++; if ({timer, speed, frozen_speed} !== 36'd0) begin errors++; $display("FAIL reset_regs: timer %0d speed %0d frozen %0d exp 0", timer, speed, frozen_speed); end
        rst = 1'b0;
    endtask

    task automatic test_waiting();
        for (int i = 1; i <= 3; i++) begin
            frame(1'b0);
            checks++; if (upd_seen !== 1'b1 || upd_after !== 1'b0) begin errors++; $display("FAIL wait_update%0d: got %b%b exp 10", i, upd_seen, upd_after); end
            checks++; if (timer !== 6'(i)) begin errors++; $display("FAIL wait_timer%0d: got %0d exp %0d", i, timer, i); end
        end
        @(posedge clk); #1 crash_req = 4'b1111;
        @(posedge clk); #1 crash_req = 4'b0;
        @(posedge clk); #1;
        checks++; if (state !== S_WAIT || speed !== 15'd0) begin errors++; $display("FAIL wait_hold: state %0d speed %0d exp 0 0", state, speed); end
    endtask

    task automatic test_run();
        pause_edge();
        frame(1'b1);
        checks++; if (state !== S_RUN || start !== 1'b1) begin errors++; $display("FAIL run_enter: state %0d start %b exp 1 1", state, start); end
        checks++; if (speed !== 15'd6144 || s_speed !== 15'd6144) begin errors++; $display("FAIL run_init: speed %0d sat %0d exp 6144 6144", speed, s_speed); end
        for (int n = 1; n <= 181; n++) begin
            frame(1'b0);
            if (n == 1) begin
                checks++; if (state !== S_RUN) begin errors++; $display("FAIL run_waitpause: state %0d exp %0d", state, S_RUN); end
                checks++; if (s_speed !== 15'd6148) begin errors++; $display("FAIL sat_step1: got %0d exp 6148", s_speed); end
            end
            if (n == 2) begin checks++; if (s_speed !== 15'd6150) begin errors++; $display("FAIL sat_step2: got %0d exp 6150", s_speed); end end
            if (n == 3) begin checks++; if (s_speed !== 15'd6150) begin errors++; $display("FAIL sat_step3: got %0d exp 6150", s_speed); end end
            if (n == 180) begin
                checks++; if (has_obstacles !== 1'b0 || speed !== 15'd6324) begin errors++; $display("FAIL run_180: obst %b speed %0d exp 0 6324", has_obstacles, speed); end
            end
        end
        checks++; if (has_obstacles !== 1'b1 || speed !== 15'd6325) begin errors++; $display("FAIL run_181: obst %b speed %0d exp 1 6325", has_obstacles, speed); end
        checks++; if (timer !== 6'd5) begin errors++; $display("FAIL timer_wrap: got %0d exp 5", timer); end
    endtask

    task automatic test_crash();
        @(posedge clk); #1 crash_req = 4'b0100;
        @(posedge clk); #1 crash_req = 4'b0;
        checks++; if (state !== S_CRASH || frozen_speed !== 15'd6325) begin errors++; $display("FAIL crash_enter: state %0d frozen %0d exp 3 6325", state, frozen_speed); end
        for (int k = 1; k <= 46; k++) begin
            if (k == 20) pause_edge();
            frame(k == 10 || k == 45 || k == 46);
            if (k == 10) begin checks++; if (state !== S_CRASH) begin errors++; $display("FAIL crash_early_jump: state %0d exp 3", state); end end
            if (k == 45) begin
                checks++; if (state !== S_CRASH || speed !== 15'd6325) begin errors++; $display("FAIL crash_hold45: state %0d speed %0d exp 3 6325", state, speed); end
            end
        end
        checks++; if (state !== S_RUN || restart !== 1'b1) begin errors++; $display("FAIL restart: state %0d restart %b exp 1 1", state, restart); end
        checks++; if (speed !== 15'd6144 || has_obstacles !== 1'b0 || frozen_speed !== 15'd6325) begin errors++; $display("FAIL restart_vals: speed %0d obst %b frozen %0d exp 6144 0 6325", speed, has_obstacles, frozen_speed); end
        @(posedge clk); #1;
        checks++; if (restart !== 1'b0) begin errors++; $display("FAIL restart_pulse: got %b exp 0", restart); end
        frame(1'b0);
        checks++; if (state !== S_RUN || speed !== 15'd6145) begin errors++; $display("FAIL crash_pause_discard: state %0d speed %0d exp 1 6145", state, speed); end
    endtask

    task automatic test_pause_crash();
        @(posedge clk); #1 pause = 1'b1; crash_req = 4'b0001;
        @(posedge clk); #1 pause = 1'b0; crash_req = 4'b0;
        checks++; if (state !== S_CRASH || frozen_speed !== 15'd6145) begin errors++; $display("FAIL pc_crash: state %0d frozen %0d exp 3 6145", state, frozen_speed); end
        frame(1'b0);
        checks++; if (state !== S_CRASH) begin errors++; $display("FAIL pc_nopause: state %0d exp 3", state); end
        recover();
        frame(1'b0);
        checks++; if (state !== S_RUN || speed !== 15'd6145) begin errors++; $display("FAIL pc_recover: state %0d speed %0d exp 1 6145", state, speed); end
    endtask

    task automatic test_pause();
        pause_edge();
        frame(1'b0);
        checks++; if (state !== S_PAUSE || speed !== 15'd6145) begin errors++; $display("FAIL pause_enter: state %0d speed %0d exp 2 6145", state, speed); end
        @(posedge clk); #1 crash_req = 4'b1000;
        @(posedge clk); #1 crash_req = 4'b0;
        repeat (20) frame(1'b0);
        checks++; if (state !== S_PAUSE || speed !== 15'd6145) begin errors++; $display("FAIL pause_hold: state %0d speed %0d exp 2 6145", state, speed); end
        pause_edge();
        frame(1'b0);
        checks++; if (state !== S_RUN || speed !== 15'd6145) begin errors++; $display("FAIL pause_resume: state %0d speed %0d exp 1 6145", state, speed); end
        frame(1'b0);
        checks++; if (speed !== 15'd6146) begin errors++; $display("FAIL pause_after: got %0d exp 6146", speed); end
    endtask

    task automatic test_mid_reset();
        int cnt;
        @(posedge clk); #1 painter_finished = 1'b1;
        @(posedge clk); #3 rst = 1'b1;
        #1;
        checks++; if (update !== 1'b0 || state !== S_WAIT || start !== 1'b0) begin errors++; $display("FAIL midrst_abort: upd %b state %0d start %b exp 0 0 0", update, state, start); end
        checks++; if (speed !== 15'd0 || timer !== 6'd0 || frozen_speed !== 15'd0) begin errors++; $display("FAIL midrst_regs: speed %0d timer %0d frozen %0d exp 0", speed, timer, frozen_speed); end
        painter_finished = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        cnt = 0;
        repeat (5) begin @(posedge clk); #1 cnt += int'(update); end
        checks++; if (cnt != 0) begin errors++; $display("FAIL midrst_noupd: got %0d updates exp 0", cnt); end
    endtask

    task automatic test_watchdog();
        int cnt, exp_cnt;
        logic [5:0] t0;
        t0 = timer;
        cnt = 0;
        repeat (300) begin @(posedge clk); #1 cnt += int'(update); end
`ifdef GAME_LOOP_WATCHDOG_EN
        exp_cnt = 3;
`else
        exp_cnt = 0;
`endif
        checks++; if (cnt != exp_cnt) begin errors++; $display("FAIL wd_updates: got %0d exp %0d", cnt, exp_cnt); end
        checks++; if (timer !== 6'((int'(t0) + exp_cnt) % 60)) begin errors++; $display("FAIL wd_timer: got %0d exp %0d", timer, (int'(t0) + exp_cnt) % 60); end
    endtask

    initial begin
        test_reset();
        test_waiting();
        test_run();
        test_crash();
        test_pause_crash();
        test_pause();
        test_mid_reset();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
